// File: rtl/serial_add_arbiter.sv
// Round-robin arbiter sharing one bit-serial adder between two requesters.
// Optional subtract mode (Sub0/Sub1 ports) is enabled by defining SERIAL_ARB_SUB_EN.
module serial_add_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Req0,
  input  logic [WIDTH-1:0] X0,
  input  logic [WIDTH-1:0] Y0,
  input  logic             Req1,
  input  logic [WIDTH-1:0] X1,
  input  logic [WIDTH-1:0] Y1,
`ifdef SERIAL_ARB_SUB_EN
  input  logic             Sub0,
  input  logic             Sub1,
`endif
  output logic             Ack0,
  output logic             Ack1,
  output logic             Busy,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             V,
  output logic             Owner
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             sub;
  } req_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             v_q, v_d;
  logic             owner_q, owner_d;
  logic             lg_q, lg_d;

  req_t req0, req1, win;
  logic gnt, any_req;
  logic s_bit, c_nxt;
  logic [WIDTH-1:0] a_shift;

  assign req0.x = X0;
  assign req0.y = Y0;
  assign req1.x = X1;
  assign req1.y = Y1;
`ifdef SERIAL_ARB_SUB_EN
  assign req0.sub = Sub0;
  assign req1.sub = Sub1;
`else
  assign req0.sub = 1'b0;
  assign req1.sub = 1'b0;
`endif

  // On a tie the requester not granted last time wins.
  assign any_req = Req0 | Req1;
  assign gnt     = (Req0 & Req1) ? ~lg_q : Req1;
  assign win     = gnt ? req1 : req0;

  assign s_bit   = a_q[0] ^ b_q[0] ^ c_q;
  assign c_nxt   = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
  assign a_shift = {s_bit, a_q[WIDTH-1:1]};

  always_ff @(negedge Clock) begin
    if (!Resetn) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      v_q     <= 1'b0;
      owner_q <= 1'b0;
      lg_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      v_q     <= v_d;
      owner_q <= owner_d;
      lg_q    <= lg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    v_d     = v_q;
    owner_d = owner_q;
    lg_d    = lg_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = SHIFT;
          a_d     = win.x;
          // Subtract is X + ~Y + 1: invert B and preset the carry.
          b_d     = win.sub ? ~win.y : win.y;
          c_d     = win.sub;
          cnt_d   = '0;
          owner_d = gnt;
          lg_d    = gnt;
        end
      end
      SHIFT: begin
        a_d   = a_shift;
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        c_d   = c_nxt;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          sum_d   = a_shift;
          cout_d  = c_nxt;
          v_d     = c_q ^ c_nxt;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign Ack0  = (state_q == DONE) & ~owner_q;
  assign Ack1  = (state_q == DONE) &  owner_q;
  assign Busy  = (state_q != IDLE);
  assign Sum   = sum_q;
  assign Cout  = cout_q;
  assign V     = v_q;
  assign Owner = owner_q;

endmodule

// File: tb/tb_serial_add_arbiter.sv
// Bench for serial_add_arbiter: vector table, corner sequences, and a
// randomized run checked against an arithmetic/round-robin reference model.
module tb_serial_add_arbiter;
  localparam int W = 4;

  logic         Clock = 1'b0;
  logic         Resetn, Req0, Req1;
  logic [W-1:0] X0, Y0, X1, Y1;
  logic         Ack0, Ack1, Busy, Cout, V, Owner;
  logic [W-1:0] Sum;
`ifdef SERIAL_ARB_SUB_EN
  logic         Sub0, Sub1;
`endif

  int n_chk = 0, n_pass = 0, cyc = 0;

  always #5 Clock = ~Clock;
  always @(negedge Clock) cyc <= cyc + 1;

  serial_add_arbiter #(.WIDTH(W)) dut (
    .Clock(Clock), .Resetn(Resetn),
    .Req0(Req0), .X0(X0), .Y0(Y0),
    .Req1(Req1), .X1(X1), .Y1(Y1),
`ifdef SERIAL_ARB_SUB_EN
    .Sub0(Sub0), .Sub1(Sub1),
`endif
    .Ack0(Ack0), .Ack1(Ack1), .Busy(Busy), .Sum(Sum),
    .Cout(Cout), .V(V), .Owner(Owner)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Returns {V, Cout, Sum} from plain two's-complement arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic sub);
    logic [W-1:0] b;
    logic [W:0]   t;
    logic         ov;
    b  = sub ? ~y : y;
    t  = {1'b0, x} + {1'b0, b} + {{W{1'b0}}, sub};
    ov = (x[W-1] == b[W-1]) && (t[W-1] != x[W-1]);
    return {ov, t};
  endfunction

  // Called at a posedge with the DUT idle; returns at a posedge with it idle again.
  task automatic run_op(input logic r0, input logic r1,
                        input logic [W-1:0] x0, input logic [W-1:0] y0,
                        input logic [W-1:0] x1, input logic [W-1:0] y1,
                        input bit drop, input bit scr,
                        output logic a0, output logic a1, output logic [W-1:0] s,
                        output logic co, output logic vv, output logic ow,
                        output int lat, output int ackc);
    Req0 = r0; Req1 = r1; X0 = x0; Y0 = y0; X1 = x1; Y1 = y1;
    @(posedge Clock);
    chk("busy_after_grant", 32'(Busy), 32'd1);
    if (drop) begin Req0 = 1'b0; Req1 = 1'b0; end
    if (scr) begin
      X0 = W'($urandom); Y0 = W'($urandom); X1 = W'($urandom); Y1 = W'($urandom);
    end
    lat = 0;
    while (!(Ack0 || Ack1) && lat < W + 4) begin
      @(posedge Clock);
      lat++;
    end
    a0 = Ack0; a1 = Ack1; s = Sum; co = Cout; vv = V; ow = Owner; ackc = cyc;
    Req0 = 1'b0; Req1 = 1'b0;
    @(posedge Clock);
    chk("ack_one_cycle", 32'({Ack0, Ack1}), 32'd0);
    chk("idle_after_done", 32'(Busy), 32'd0);
    chk("sum_held", 32'(Sum), 32'(s));
  endtask

  task automatic do_reset();
    Resetn = 1'b0; Req0 = 1'b0; Req1 = 1'b0;
    repeat (2) @(posedge Clock);
    Resetn = 1'b1;
  endtask

  typedef struct {
    logic r0, r1;
    logic [W-1:0] x0, y0, x1, y1;
    bit drop, scr;
    logic e1;
    logic [W-1:0] es;
    logic ec, ev;
  } vec_t;

  function automatic vec_t mk(input logic r0, input logic r1,
                              input logic [W-1:0] x0, input logic [W-1:0] y0,
                              input logic [W-1:0] x1, input logic [W-1:0] y1,
                              input bit drop, input bit scr, input logic e1,
                              input logic [W-1:0] es, input logic ec, input logic ev);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.x0 = x0; v.y0 = y0; v.x1 = x1; v.y1 = y1;
    v.drop = drop; v.scr = scr; v.e1 = e1; v.es = es; v.ec = ec; v.ev = ev;
    return v;
  endfunction

  vec_t tv[9];

  initial begin
    logic a0, a1, co, vv, ow, win, lg_m, sub_w, r0, r1;
    logic [W-1:0] s, x0, y0, x1, y1;
    logic [W+1:0] ex;
    int lat, ackc, prev_ack;
    bit seen;

    tv[0] = mk(1, 0,  5,  2,  0, 0, 0, 0, 0,  7, 0, 0);
    tv[1] = mk(0, 1,  0,  0,  7, 1, 0, 0, 1,  8, 0, 1);
    tv[2] = mk(0, 1,  0,  0, 15, 1, 0, 0, 1,  0, 1, 0);
    tv[3] = mk(1, 1,  3,  4,  9, 9, 0, 0, 0,  7, 0, 0);  // tie, pointer at 1
    tv[4] = mk(1, 1,  3,  4,  9, 9, 0, 0, 1,  2, 1, 1);  // tie, pointer at 0
    tv[5] = mk(1, 1,  8,  8,  9, 9, 0, 0, 0,  0, 1, 1);
    tv[6] = mk(1, 0,  5,  6,  0, 0, 1, 1, 0, 11, 0, 1);  // drop Req and scramble operands
    tv[7] = mk(0, 1,  0,  0, 12, 3, 1, 0, 1, 15, 0, 0);
    tv[8] = mk(1, 0, 15, 15,  0, 0, 0, 1, 0, 14, 1, 0);

    Resetn = 1'b0; Req0 = 1'b0; Req1 = 1'b0;
    X0 = '0; Y0 = '0; X1 = '0; Y1 = '0;
`ifdef SERIAL_ARB_SUB_EN
    Sub0 = 1'b0; Sub1 = 1'b0;
`endif
    repeat (2) @(posedge Clock);
    chk("rst_ack0", 32'(Ack0), 32'd0);
    chk("rst_ack1", 32'(Ack1), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_sum", 32'(Sum), 32'd0);
    chk("rst_cout", 32'(Cout), 32'd0);
    chk("rst_v", 32'(V), 32'd0);
    chk("rst_owner", 32'(Owner), 32'd0);
    Resetn = 1'b1;
    @(posedge Clock);

    for (int i = 0; i < 9; i++) begin
      run_op(tv[i].r0, tv[i].r1, tv[i].x0, tv[i].y0, tv[i].x1, tv[i].y1,
             tv[i].drop, tv[i].scr, a0, a1, s, co, vv, ow, lat, ackc);
      chk($sformatf("tv%0d_ack0", i), 32'(a0), 32'(!tv[i].e1));
      chk($sformatf("tv%0d_ack1", i), 32'(a1), 32'(tv[i].e1));
      chk($sformatf("tv%0d_owner", i), 32'(ow), 32'(tv[i].e1));
      chk($sformatf("tv%0d_sum", i), 32'(s), 32'(tv[i].es));
      chk($sformatf("tv%0d_cout", i), 32'(co), 32'(tv[i].ec));
      chk($sformatf("tv%0d_v", i), 32'(vv), 32'(tv[i].ev));
      chk($sformatf("tv%0d_latency", i), 32'(lat), 32'(W));
    end

    // Reset two cycles after a grant aborts the operation silently.
    Req0 = 1'b0; Req1 = 1'b1; X1 = 4'd5; Y1 = 4'd5;
    @(posedge Clock);
    chk("abort_busy", 32'(Busy), 32'd1);
    @(posedge Clock);
    Resetn = 1'b0; Req1 = 1'b0;
    @(posedge Clock);
    chk("abort_busy_clr", 32'(Busy), 32'd0);
    chk("abort_acks", 32'({Ack0, Ack1}), 32'd0);
    chk("abort_sum", 32'(Sum), 32'd0);
    chk("abort_cout", 32'(Cout), 32'd0);
    chk("abort_v", 32'(V), 32'd0);
    chk("abort_owner", 32'(Owner), 32'd0);
    Resetn = 1'b1;
    seen = 1'b0;
    repeat (W + 2) begin
      @(posedge Clock);
      if (Ack0 || Ack1 || Busy) seen = 1'b1;
    end
    chk("abort_no_ack", 32'(seen), 32'd0);
    run_op(1, 0, 3, 3, 0, 0, 0, 0, a0, a1, s, co, vv, ow, lat, ackc);
    chk("post_abort_ack0", 32'(a0), 32'd1);
    chk("post_abort_sum", 32'(s), 32'd6);

    // Both held high: grants alternate, one op every W+2 cycles.
    do_reset();
    @(posedge Clock);
    prev_ack = 0;
    for (int i = 0; i < 4; i++) begin
      run_op(1, 1, W'(i + 1), 4'd2, 4'd9, W'(i), 0, 0, a0, a1, s, co, vv, ow, lat, ackc);
      chk($sformatf("alt%0d_owner", i), 32'(ow), 32'(i % 2));
      chk($sformatf("alt%0d_acks", i), 32'({a1, a0}), (i % 2) ? 32'd2 : 32'd1);
      if (i > 0) chk($sformatf("alt%0d_spacing", i), 32'(ackc - prev_ack), 32'(W + 2));
      prev_ack = ackc;
    end

`ifdef SERIAL_ARB_SUB_EN
    Sub0 = 1'b1;
    run_op(1, 0, 2, 5, 0, 0, 0, 0, a0, a1, s, co, vv, ow, lat, ackc);
    chk("sub_ack0", 32'(a0), 32'd1);
    chk("sub_sum", 32'(s), 32'd13);
    chk("sub_cout", 32'(co), 32'd0);
    chk("sub_v", 32'(vv), 32'd0);
    Sub0 = 1'b0;
`endif

    // Randomized run against the reference model.
    do_reset();
    @(posedge Clock);
    lg_m = 1'b1;
    for (int i = 0; i < 150; i++) begin
      r0 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      x0 = W'($urandom); y0 = W'($urandom); x1 = W'($urandom); y1 = W'($urandom);
      sub_w = 1'b0;
`ifdef SERIAL_ARB_SUB_EN
      Sub0 = 1'($urandom_range(0, 1));
      Sub1 = 1'($urandom_range(0, 1));
`endif
      if (!r0 && !r1) begin
        Req0 = 1'b0; Req1 = 1'b0;
        @(posedge Clock);
        chk("rnd_idle", 32'(Busy), 32'd0);
        continue;
      end
      win  = (r0 && r1) ? !lg_m : r1;
      lg_m = win;
`ifdef SERIAL_ARB_SUB_EN
      sub_w = win ? Sub1 : Sub0;
`endif
      ex = win ? model(x1, y1, sub_w) : model(x0, y0, sub_w);
      run_op(r0, r1, x0, y0, x1, y1, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
             a0, a1, s, co, vv, ow, lat, ackc);
      chk("rnd_acks", 32'({a1, a0}), win ? 32'd2 : 32'd1);
      chk("rnd_owner", 32'(ow), 32'(win));
      chk("rnd_sum", 32'(s), 32'(ex[W-1:0]));
      chk("rnd_cout", 32'(co), 32'(ex[W]));
      chk("rnd_v", 32'(vv), 32'(ex[W+1]));
      chk("rnd_latency", 32'(lat), 32'(W));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
